// File: rtl/ifetch_unit_if.sv
// Instruction-memory port of the fetch unit: one read request channel
// (valid/ready with a word address) and one response channel (valid with
// data and a bus-error flag, no backpressure).
//   master : fetch unit side (drives request, receives response)
//   slave  : memory side (accepts request, drives response)
interface ifetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end of the multi-cycle RV32 core.
// Issues one word read per fetch_req, latches the returned word into ir with
// its fetch address in pc_ir, and reports bus errors / timeouts as faults.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   pc, fetch_req     fetch address and start strobe from the core FSM
//   flush             trap/return redirect, aborts any fetch in flight
//   imem              instruction-memory port (ifetch_unit_if.master)
//   ir, pc_ir         latched instruction and its PC
//   ir_valid          one-cycle pulse when ir/pc_ir take a good instruction
//   fetch_busy        high whenever the FSM is not IDLE
//   fetch_fault       one-cycle pulse on a failed fetch
//   fault_cause       0 bus error, 1 timeout, 2 misaligned (held)
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to fault on pc[1:0]!=0
// instead of silently aligning the address.
module ifetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] RESET_IR       = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                fetch_req,
    input  logic                flush,
    ifetch_unit_if.master       imem,
    output logic [31:0]         ir,
    output logic [31:0]         pc_ir,
    output logic                ir_valid,
    output logic                fetch_busy,
    output logic                fetch_fault,
    output logic [1:0]          fault_cause
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] CAUSE_BUS  = 2'd0;
    localparam logic [1:0] CAUSE_TMO  = 2'd1;
    localparam logic [1:0] CAUSE_MISA = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      addr_q,      addr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [31:0]      ir_q,        ir_d;
    logic [31:0]      pc_ir_q,     pc_ir_d;
    logic             ir_valid_q,  ir_valid_d;
    logic             fault_q,     fault_d;
    logic [1:0]       cause_q,     cause_d;
    logic             req_valid_q, req_valid_d;
    logic             busy_q,      busy_d;

    // Low PC bits only matter when the misalignment check is built in.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        pc_ir_d    = pc_ir_q;
        ir_valid_d = 1'b0;
        fault_d    = 1'b0;
        cause_d    = cause_q;

        if (flush) begin
            ir_d = RESET_IR;
            unique case (state_q)
                S_REQ:   state_d = S_IDLE;
                // A beat arriving with the flush is the outstanding response;
                // it is discarded here so DRAIN never waits for a beat that
                // will not come.
                S_WAIT:  state_d = imem.imem_rsp_valid ? S_IDLE : S_DRAIN;
                default: state_d = state_q;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            cause_d = CAUSE_MISA;
                        end else begin
                            addr_d  = {pc[31:2], 2'b00};
                            state_d = S_REQ;
                        end
`else
                        addr_d  = {pc[31:2], 2'b00};
                        state_d = S_REQ;
`endif
                    end
                end
                S_REQ: begin
                    if (imem.imem_req_ready) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_WAIT: begin
                    // A response in the timeout cycle wins over the timeout.
                    if (imem.imem_rsp_valid) begin
                        state_d = S_IDLE;
                        if (imem.imem_rsp_err) begin
                            fault_d = 1'b1;
                            cause_d = CAUSE_BUS;
                        end else begin
                            ir_d       = imem.imem_rsp_data;
                            pc_ir_d    = addr_q;
                            ir_valid_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        fault_d = 1'b1;
                        cause_d = CAUSE_TMO;
                        state_d = S_DRAIN;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_rsp_valid) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        req_valid_d = (state_d == S_REQ);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            ir_q        <= RESET_IR;
            pc_ir_q     <= '0;
            ir_valid_q  <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_BUS;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            pc_ir_q     <= pc_ir_d;
            ir_valid_q  <= ir_valid_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            req_valid_q <= req_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = addr_q;
    assign ir                  = ir_q;
    assign pc_ir               = pc_ir_q;
    assign ir_valid            = ir_valid_q;
    assign fetch_busy          = busy_q;
    assign fetch_fault         = fault_q;
    assign fault_cause         = cause_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end of the multi-cycle RV32 core.
- Consumes the architectural PC and a fetch strobe from the core state machine, and issues one word read per fetch on a valid/ready instruction-memory port.
- Latches the returned word into IR together with the PC it was fetched from (pc_ir, feeding the PC-update and decode logic).
- Reports bus errors and timeouts as fetch faults for the trap logic.

Parameters:
- TIMEOUT_CYCLES, 256, cycles spent in WAIT before the fetch is abandoned with a fault. Legal range 2..65535.
- RESET_IR, 32'h0000_0013, IR value after reset and after a flush (NOP, addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- pc  in  32  current PC from the PC register
- fetch_req  in  1  single-cycle pulse from the core FSM: start a fetch at pc
- flush  in  1  trap/return redirect; abort any fetch in flight
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts the request
- imem_addr  out  32  word address, {pc[31:2],2'b00}
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  32  instruction word
- imem_rsp_err  in  1  bus error, qualified by imem_rsp_valid
- ir  out  32  latched instruction
- pc_ir  out  32  PC of the instruction in ir
- ir_valid  out  1  one-cycle pulse: ir/pc_ir updated with a good instruction
- fetch_busy  out  1  high in any state other than IDLE
- fetch_fault  out  1  one-cycle pulse: fetch failed
- fault_cause  out  2  0 = bus error, 1 = timeout, 2 = misaligned; held until the next fault

Behaviour:
- Reset, synchronous on rst=1 at a clock edge:
  - state=IDLE; ir=RESET_IR; pc_ir=0; fault_cause=0.
  - ir_valid=0, fetch_fault=0, imem_req_valid=0; timeout counter=0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - fetch_req=1 captures pc into an address register and moves to REQ.
  - fetch_req while not IDLE is ignored.
- REQ:
  - imem_req_valid=1; imem_addr is held stable until accepted.
  - On imem_req_ready=1 go to WAIT and clear the counter.
  - There is no timeout in REQ.
- WAIT, on imem_rsp_valid=1:
  - err=0: ir<=rsp_data, pc_ir<=captured address, ir_valid=1 next cycle, go to IDLE.
  - err=1: ir and pc_ir are unchanged, fetch_fault=1, fault_cause=0, go to IDLE.
- WAIT, timeout:
  - The counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no response: fetch_fault=1, fault_cause=1, go to DRAIN.
- DRAIN:
  - Discards exactly one imem_rsp_valid beat, then goes to IDLE.
  - fetch_busy stays high; ir and pc_ir are not touched.
- Latency with zero-wait memory (ready and rsp in the same cycle as asked): fetch_req at cycle N, request at N+1, response at N+2, ir_valid at N+3.
- Flush, which has priority over every other event in the same cycle:
  - In IDLE: no effect on state; ir<=RESET_IR.
  - In REQ: the request is dropped at that edge (imem_req_valid low next cycle); go to IDLE.
  - In WAIT: go to DRAIN; the outstanding response is discarded.
  - In DRAIN: stay in DRAIN.
  - In all cases ir_valid and fetch_fault are suppressed for the aborted fetch.
- Simultaneous flush and fetch_req in IDLE: the flush is applied and fetch_req is ignored.
- A response arriving in the same cycle as the timeout is accepted normally; the timeout does not fire.
- imem_rsp_valid outside WAIT/DRAIN is ignored.
- Reset mid-fetch returns to IDLE immediately; a late response after reset is ignored in IDLE.
- The address always has bits [1:0] forced to 0.
- The counter is wide enough for TIMEOUT_CYCLES and saturates; it never wraps.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined: at fetch_req in IDLE, if pc[1:0]!=0, no request is issued. fetch_fault pulses on the next cycle, fault_cause=2, state stays IDLE, and ir and pc_ir are unchanged.
- Undefined: pc[1:0] is silently ignored and fault_cause never takes value 2.

Test Plan:
- Zero-wait fetch: pc=0x0000_0100, fetch_req; memory returns 0x0010_0093 -> ir=0x0010_0093, pc_ir=0x100, ir_valid high exactly at N+3.
- Backpressure: imem_req_ready low for 5 cycles -> imem_addr stable at 0x100 throughout, one request accepted, single ir_valid.
- Bus error: rsp_valid with err=1 -> fetch_fault pulse, fault_cause=0, ir keeps its previous value, no ir_valid.
- Timeout: TIMEOUT_CYCLES=8, no response -> fetch_fault on the 8th WAIT cycle, fault_cause=1. A response 3 cycles later is discarded; the next fetch at 0x104 completes normally.
- Flush in WAIT: flush 1 cycle after request acceptance, response 2 cycles later -> no ir_valid, ir=0x0000_0013. A new fetch at 0x200 returns its own data.
- With IFETCH_MISALIGN_CHECK_EN: pc=0x102 -> no imem_req_valid, fault_cause=2, fetch_fault pulse.
